// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: CPU request/response and memory block-transfer signals
// for the direct-mapped cache controller. The cache binds to the slave
// modport; the CPU/memory side (datapath or bench) binds to the master modport.
interface dm_cache_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4
);
  localparam int OFF_W = $clog2(WORDS);

  // CPU side
  logic                      cpu_read;
  logic                      cpu_write;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_busy;

  // Memory side, one whole line per transfer
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-OFF_W-1:0]   mem_addr;
  logic [DATA_W*WORDS-1:0]   mem_wdata;
  logic [DATA_W*WORDS-1:0]   mem_rdata;
  logic                      mem_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, allocate-on-miss data cache.
// Address layout is {tag, index, offset}. A miss on a dirty line first writes
// the old line back (WRITEBACK), then fetches the new line (ALLOCATE), then
// the held request is re-evaluated in IDLE where it hits.
// Optional feature: define CACHE_STATS_EN to build saturating 16-bit hit and
// miss counters; without it hit_count/miss_count are tied to zero.
// LINES and WORDS must be powers of two and LINES must be at least 2.
module dm_cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 8,
  parameter int WORDS  = 4
) (
  input  logic            clk,
  input  logic            rst,
  dm_cache_ctrl_if.slave  bus,
  output logic [15:0]     hit_count,
  output logic [15:0]     miss_count
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = DATA_W * WORDS;
  localparam int BLK_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  // Line storage; only valid/dirty are reset
  logic [LINES-1:0]    valid_r;
  logic [LINES-1:0]    dirty_r;
  logic [TAG_W-1:0]    tag_r  [LINES];
  logic [LINE_W-1:0]   data_r [LINES];

  // Address decode and indexed line view
  logic [TAG_W-1:0]    tag_s;
  logic [IDX_W-1:0]    idx_s;
  logic [OFF_W-1:0]    off_s;
  logic                req_s;
  logic                is_write_s;
  logic                hit_s;
  logic [TAG_W-1:0]    line_tag_s;
  logic [LINE_W-1:0]   line_data_s;
  logic                line_valid_s;
  logic                line_dirty_s;
  logic [DATA_W-1:0]   line_word_s;
  logic [LINE_W-1:0]   wr_line_s;

  // FSM-driven controls and outputs
  logic                wr_hit_s;
  logic                fill_s;
  logic                miss_start_s;
  logic                cpu_busy_s;
  logic [DATA_W-1:0]   cpu_rdata_s;
  logic                mem_read_s;
  logic                mem_write_s;
  logic [BLK_W-1:0]    mem_addr_s;
  logic [LINE_W-1:0]   mem_wdata_s;

  assign tag_s        = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign idx_s        = bus.cpu_addr[OFF_W +: IDX_W];
  assign off_s        = bus.cpu_addr[OFF_W-1:0];
  assign req_s        = bus.cpu_read | bus.cpu_write;
  assign is_write_s   = bus.cpu_write;
  assign line_tag_s   = tag_r[idx_s];
  assign line_data_s  = data_r[idx_s];
  assign line_valid_s = valid_r[idx_s];
  assign line_dirty_s = dirty_r[idx_s];
  assign hit_s        = line_valid_s && (line_tag_s == tag_s);

  // Select the addressed word and build the line image after a write hit
  always_comb begin
    line_word_s = line_data_s[int'(off_s)*DATA_W +: DATA_W];
    wr_line_s   = line_data_s;
    wr_line_s[int'(off_s)*DATA_W +: DATA_W] = bus.cpu_wdata;
  end

  // Next-state and output decode of the miss-handling FSM
  always_comb begin
    state_nxt_s  = state_r;
    wr_hit_s     = 1'b0;
    fill_s       = 1'b0;
    miss_start_s = 1'b0;
    cpu_busy_s   = 1'b0;
    cpu_rdata_s  = {DATA_W{1'b0}};
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_addr_s   = {BLK_W{1'b0}};
    mem_wdata_s  = {LINE_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          wr_hit_s = is_write_s;
          // A simultaneous read+write is a write: no read data is driven
          if (is_write_s) begin
            cpu_rdata_s = {DATA_W{1'b0}};
          end else begin
            cpu_rdata_s = line_word_s;
          end
          state_nxt_s = IDLE;
        end else if (req_s) begin
          cpu_busy_s   = 1'b1;
          miss_start_s = 1'b1;
          if (line_valid_s && line_dirty_s) begin
            state_nxt_s = WRITEBACK;
          end else begin
            state_nxt_s = ALLOCATE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        cpu_busy_s  = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = {line_tag_s, idx_s};
        mem_wdata_s = line_data_s;
        if (bus.mem_ready) begin
          state_nxt_s = ALLOCATE;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        cpu_busy_s = 1'b1;
        mem_read_s = 1'b1;
        mem_addr_s = {tag_s, idx_s};
        if (bus.mem_ready) begin
          fill_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ALLOCATE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Valid/dirty tracking: a fill makes the line clean, a write hit dirties it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
      dirty_r[idx_s] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays; a fill coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && fill_s) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= bus.mem_rdata;
    end else if (!rst && wr_hit_s) begin
      data_r[idx_s] <= wr_line_s;
    end
  end

  assign bus.cpu_busy  = cpu_busy_s;
  assign bus.cpu_rdata = cpu_rdata_s;
  assign bus.mem_read  = mem_read_s;
  assign bus.mem_write = mem_write_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

`ifdef CACHE_STATS_EN
  logic        fill_done_r;
  logic        count_hit_s;
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // The IDLE cycle right after a fill is the replay of a counted miss
  assign count_hit_s = (state_r == IDLE) && req_s && hit_s && !fill_done_r;

  // Remember that the previous cycle completed a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_done_r <= 1'b0;
    end else begin
      fill_done_r <= fill_s;
    end
  end

  // Saturating hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else begin
      if (count_hit_s && (hit_cnt_r != 16'hFFFF)) begin
        hit_cnt_r <= hit_cnt_r + 16'd1;
      end
      if (miss_start_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed scenarios followed by random traffic. The
// reference is a flat byte memory holding the latest written value of every
// address, plus a per-line valid/dirty/tag/words view used to predict misses,
// write-backs and transfer contents. The bench also acts as block memory.
module tb_dm_cache_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LINES  = 8;
  localparam int WORDS  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

  dm_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_blk [64];    // backing memory, one 4-byte block per entry
  logic [7:0]  golden  [256];   // latest value of every byte address
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [7:0]  m_word  [8][4];
  int          exp_hits;
  int          exp_misses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [2:0] ix);
    return {m_word[ix][3], m_word[ix][2], m_word[ix][1], m_word[ix][0]};
  endfunction

  // Cache contents are lost on reset; latest values fall back to memory
  task automatic reset_model();
    for (int l = 0; l < 8; l++) begin
      m_valid[l] = 1'b0;
      m_dirty[l] = 1'b0;
    end
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        golden[b*4 + w] = mem_blk[b][w*8 +: 8];
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic step();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"},   {16'd0, hit_count},  exp_hits);
    chk({tag, "_misses"}, {16'd0, miss_count}, exp_misses);
`else
    chk({tag, "_hits"},   {16'd0, hit_count},  32'd0);
    chk({tag, "_misses"}, {16'd0, miss_count}, 32'd0);
`endif
  endtask

  // One CPU request from issue to completion, acting as memory on a miss
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    logic [2:0] t;
    logic [2:0] ix;
    logic [1:0] o;
    logic [5:0] blk;
    logic       hit;
    int         lat;
    t   = a[7:5];
    ix  = a[4:2];
    o   = a[1:0];
    hit = m_valid[ix] && (m_tag[ix] == t);
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    #1;
    chk("busy_first", {31'd0, bus.cpu_busy}, hit ? 32'd0 : 32'd1);
    if (!hit) begin
      exp_misses++;
      chk("idle_no_mem", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      if (m_valid[ix] && m_dirty[ix]) begin
        blk = {m_tag[ix], ix};
        lat = $urandom_range(0, 2);
        for (int c = 0; c <= lat; c++) begin
          step();
          chk("wb_mem_write", {31'd0, bus.mem_write}, 32'd1);
          chk("wb_mem_read",  {31'd0, bus.mem_read},  32'd0);
          chk("wb_busy",      {31'd0, bus.cpu_busy},  32'd1);
          chk("wb_addr",      {26'd0, bus.mem_addr},  {26'd0, blk});
          chk("wb_data",      bus.mem_wdata,          line_of(ix));
          if (c == lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = $urandom;
          end
        end
        mem_blk[blk] = line_of(ix);
      end
      blk = {t, ix};
      lat = $urandom_range(0, 3);
      for (int c = 0; c <= lat; c++) begin
        step();
        chk("al_mem_read",  {31'd0, bus.mem_read},  32'd1);
        chk("al_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("al_busy",      {31'd0, bus.cpu_busy},  32'd1);
        chk("al_addr",      {26'd0, bus.mem_addr},  {26'd0, blk});
        chk("al_wdata",     bus.mem_wdata,          32'd0);
        if (c == lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_blk[blk];
        end
      end
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix]   = t;
      for (int w = 0; w < 4; w++) m_word[ix][w] = mem_blk[blk][w*8 +: 8];
      step();
      chk("fill_busy_low", {31'd0, bus.cpu_busy}, 32'd0);
      chk("fill_mem_off",  {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    end else begin
      exp_hits++;
    end
    chk("idle_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
    chk("rdata", {24'd0, bus.cpu_rdata}, (rd && !wr) ? {24'd0, golden[a]} : 32'd0);
    if (wr) begin
      golden[a]    = wd;
      m_word[ix][o] = wd;
      m_dirty[ix]  = 1'b1;
    end
    step();
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    int         mode;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
    for (int b = 0; b < 64; b++) mem_blk[b] = $urandom;
    mem_blk[6'h09] = 32'h44332211;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_model();
    chk("rst_rdata",     {24'd0, bus.cpu_rdata}, 32'd0);
    chk("rst_busy",      {31'd0, bus.cpu_busy},  32'd0);
    chk("rst_mem_rw",    {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_mem_addr",  {26'd0, bus.mem_addr},  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
    check_stats("rst");
    step();

    // Clean miss on 0x25, write hit 0x26, read-back, dirty miss on 0x45
    access(1'b1, 1'b0, 8'h25, 8'h00);
    access(1'b0, 1'b1, 8'h26, 8'hAB);
    access(1'b1, 1'b0, 8'h26, 8'h00);
    access(1'b1, 1'b0, 8'h45, 8'h00);
    check_stats("scen3");

    // Reset while ALLOCATE holds, with a mem_ready arriving on the reset edge
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 8'h25;
    #1;
    chk("rm_busy", {31'd0, bus.cpu_busy}, 32'd1);
    step();
    chk("rm_mem_read", {31'd0, bus.mem_read}, 32'd1);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    step();
    rst          = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    chk("rm_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rm_busy_low", {31'd0, bus.cpu_busy}, 32'd0);
    reset_model();
    check_stats("rm");
    step();
    access(1'b1, 1'b0, 8'h25, 8'h00);

    // Read and write together execute as a write
    access(1'b1, 1'b1, 8'h25, 8'h5A);
    access(1'b1, 1'b0, 8'h25, 8'h00);

    // Random traffic over a few conflicting tags, with stray mem_ready in IDLE
    for (int n = 0; n < 300; n++) begin
      a    = {$urandom_range(0, 3) == 0 ? 3'd7 : 3'($urandom_range(0, 2)), 5'($urandom)};
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = $urandom;
        #1;
        chk("stray_ready_busy", {31'd0, bus.cpu_busy}, 32'd0);
        step();
        chk("stray_ready_mem", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      end
      access(mode != 1, mode != 0, a, 8'($urandom));
    end
    check_stats("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
